// File: rtl/f_mult_seq.sv
// f_mult_seq: sequential binary64 multiplier.
// One operand pair is accepted while idle. Operands with a NaN or Inf
// exponent are flagged as errors. Zero and subnormal operands give a signed
// zero. All other operands go through a 53-iteration shift-add mantissa
// multiply, followed by normalisation with truncation.
module f_mult_seq #(
    parameter int FLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            up_valid,
    input  logic [FLEN-1:0] a,
    input  logic [FLEN-1:0] b,
    output logic [FLEN-1:0] res,
    output logic            down_valid,
    output logic            busy,
    output logic            error
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CHK  = 3'd1,
        MUL  = 3'd2,
        NORM = 3'd3,
        OUT  = 3'd4
    } state_t;

    state_t                state_r;
    state_t                state_s;

    logic [FLEN-1:0]       a_r;
    logic [FLEN-1:0]       b_r;
    logic [105:0]          mcand_r;
    logic [52:0]           mplier_r;
    logic [105:0]          acc_r;
    logic [5:0]            cnt_r;

    logic [FLEN-1:0]       res_r;
    logic                  err_r;
    logic                  dv_r;
    logic                  busy_r;

    logic                  sign_s;
    logic [10:0]           ea_s;
    logic [10:0]           eb_s;
    logic                  special_s;
    logic                  zero_s;
    logic signed [12:0]    exp_s;
    logic [51:0]           frac_s;

    logic                  load_out_s;
    logic [FLEN-1:0]       out_res_s;
    logic                  out_err_s;

    assign res        = res_r;
    assign error      = err_r;
    assign down_valid = dv_r;
    assign busy       = busy_r;

    // Decode the captured operands and normalise the finished product.
    always_comb begin
        sign_s    = a_r[63] ^ b_r[63];
        ea_s      = a_r[62:52];
        eb_s      = b_r[62:52];
        special_s = (ea_s == 11'h7FF) || (eb_s == 11'h7FF);
        zero_s    = (ea_s == 11'h000) || (eb_s == 11'h000);
        // The exponent is kept 13 bits wide and signed, so that both overflow
        // and underflow can be seen without the value wrapping.
        exp_s     = $signed({2'b00, ea_s}) + $signed({2'b00, eb_s})
                  - (acc_r[105] ? 13'sd1022 : 13'sd1023);
        if (acc_r[105]) begin
            frac_s = acc_r[104:53];
        end else begin
            frac_s = acc_r[103:52];
        end
    end

    // Next-state logic and the result to be loaded on the edge entering OUT.
    always_comb begin
        state_s    = state_r;
        load_out_s = 1'b0;
        out_res_s  = {FLEN{1'b0}};
        out_err_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (up_valid) begin
                    state_s = CHK;
                end else begin
                    state_s = IDLE;
                end
            end
            CHK: begin
                if (special_s) begin
                    state_s    = OUT;
                    load_out_s = 1'b1;
                    out_res_s  = {FLEN{1'b0}};
                    out_err_s  = 1'b1;
                end else if (zero_s) begin
                    state_s    = OUT;
                    load_out_s = 1'b1;
                    out_res_s  = {sign_s, 63'd0};
                    out_err_s  = 1'b0;
                end else begin
                    state_s = MUL;
                end
            end
            MUL: begin
                if (cnt_r == 6'd52) begin
                    state_s = NORM;
                end else begin
                    state_s = MUL;
                end
            end
            NORM: begin
                state_s    = OUT;
                load_out_s = 1'b1;
                if (exp_s >= 13'sd2047) begin
                    out_res_s = {sign_s, 11'h7FF, 52'd0};
                    out_err_s = 1'b1;
                end else if (exp_s <= 13'sd0) begin
                    out_res_s = {sign_s, 63'd0};
                    out_err_s = 1'b0;
                end else begin
                    out_res_s = {sign_s, exp_s[10:0], frac_s};
                    out_err_s = 1'b0;
                end
            end
            OUT: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture and the shift-add multiply datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r      <= {FLEN{1'b0}};
            b_r      <= {FLEN{1'b0}};
            mcand_r  <= 106'd0;
            mplier_r <= 53'd0;
            acc_r    <= 106'd0;
            cnt_r    <= 6'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (up_valid) begin
                        a_r <= a;
                        b_r <= b;
                    end
                end
                CHK: begin
                    if (!special_s && !zero_s) begin
                        mcand_r  <= {53'd0, 1'b1, a_r[51:0]};
                        mplier_r <= {1'b1, b_r[51:0]};
                        acc_r    <= 106'd0;
                        cnt_r    <= 6'd0;
                    end
                end
                MUL: begin
                    if (mplier_r[0]) begin
                        acc_r <= acc_r + mcand_r;
                    end
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + 6'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Registered outputs. The result and error flag are held until the next OUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_r  <= {FLEN{1'b0}};
            err_r  <= 1'b0;
            dv_r   <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            dv_r   <= load_out_s;
            busy_r <= (state_s != IDLE);
            if (load_out_s) begin
                res_r <= out_res_s;
                err_r <= out_err_s;
            end
        end
    end

endmodule
